// File: rtl/intr_pkg.sv
// Shared constants for the memory-mapped interrupt controller.
package intr_pkg;

  localparam int unsigned INTR_DATA_W = 32;
  localparam int unsigned INTR_OFF_W  = 8;
  localparam int unsigned INTR_IDX_W  = 5;

  // Byte offsets of the registers inside the 256-byte window
  localparam logic [INTR_OFF_W-1:0] INTR_PEND    = 8'h00;
  localparam logic [INTR_OFF_W-1:0] INTR_MASK    = 8'h04;
  localparam logic [INTR_OFF_W-1:0] INTR_EDGE    = 8'h08;
  localparam logic [INTR_OFF_W-1:0] INTR_SWSET   = 8'h0C;
  localparam logic [INTR_OFF_W-1:0] INTR_ACTIVE  = 8'h10;
  localparam logic [INTR_OFF_W-1:0] INTR_HIGHEST = 8'h14;

  // Reset values, sliced down to NSRC bits by the user
  localparam logic [INTR_DATA_W-1:0] INTR_MASK_RST = 32'h0000_0000;
  localparam logic [INTR_DATA_W-1:0] INTR_EDGE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/intr_sync.sv
// One-bit synchroniser with a previous-value flop for rising-edge detection.
module intr_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Shift the raw input through the synchroniser chain
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  // Remember the last synchronised value; tracked regardless of source mode
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b0;
    end else begin
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronises sources, latches pending, masks, and
// exposes PEND/MASK/EDGE/SWSET/ACTIVE/HIGHEST on the core's store/load bus.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned NSRC        = 8,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            memwrite,
  input  logic [31:0]     dataadr,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  output logic [NSRC-1:0] interrupts
);

  if (NSRC > 31 || NSRC < 1) begin : g_bad_nsrc
    $error("intr_ctrl: NSRC must be in 1..31");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("intr_ctrl: SYNC_STAGES must be at least 2");
  end

  logic [NSRC-1:0] lvl;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] edge_q;
  logic [NSRC-1:0] pend_nxt;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] wdata;

  logic                  hit;
  logic [INTR_OFF_W-1:0] reg_off;
  logic                  wr_en;
  logic                  wr_pend;
  logic                  wr_mask;
  logic                  wr_edge;
  logic                  wr_swset;

  logic                  any_active;
  logic [INTR_IDX_W-1:0] hi_idx;

  // Byte-lane bits and store data above NSRC carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{dataadr[1:0], writedata[31:NSRC]};

  // One synchroniser per source
  for (genvar g = 0; g < NSRC; g++) begin : g_sync
    intr_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (src[g]),
      .level (lvl[g]),
      .rise  (rise[g])
    );
  end

  // Address decode and write strobes
  always_comb begin
    hit      = (dataadr[31:8] == BASE_ADDR[31:8]);
    reg_off  = {dataadr[7:2], 2'b00};
    wr_en    = memwrite & hit;
    wr_pend  = wr_en && (reg_off == INTR_PEND);
    wr_mask  = wr_en && (reg_off == INTR_MASK);
    wr_edge  = wr_en && (reg_off == INTR_EDGE);
    wr_swset = wr_en && (reg_off == INTR_SWSET);
    wdata    = writedata[NSRC-1:0];
  end

  // Pending next-state: edge sources set-wins-over-W1C, level sources follow sync
  always_comb begin
    logic [NSRC-1:0] set_v;
    logic [NSRC-1:0] clr_v;
    set_v    = rise | (wr_swset ? wdata : '0);
    clr_v    = wr_pend ? wdata : '0;
    pend_nxt = (edge_q & (set_v | (pend & ~clr_v))) | (~edge_q & lvl);
  end

  assign active = pend & mask;

  // Register file and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      pend       <= '0;
      mask       <= INTR_MASK_RST[NSRC-1:0];
      edge_q     <= INTR_EDGE_RST[NSRC-1:0];
      interrupts <= '0;
    end else begin
      pend       <= pend_nxt;
      interrupts <= active;
      if (wr_mask) mask   <= wdata;
      if (wr_edge) edge_q <= wdata;
    end
  end

  // Priority encoder: lowest-numbered active source wins
  always_comb begin
    any_active = |active;
    hi_idx     = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) hi_idx = INTR_IDX_W'(i);
    end
  end

  // Combinational read mux; returns pre-write state
  always_comb begin
    readdata = '0;
    if (hit) begin
      case (reg_off)
        INTR_PEND:    readdata = 32'(pend);
        INTR_MASK:    readdata = 32'(mask);
        INTR_EDGE:    readdata = 32'(edge_q);
        INTR_ACTIVE:  readdata = 32'(active);
        INTR_HIGHEST: readdata = any_active ? {1'b1, 26'd0, hi_idx} : 32'd0;
        default:      readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl.
module tb_intr_ctrl;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [31:0] A_PEND    = BASE + 32'h00;
  localparam logic [31:0] A_MASK    = BASE + 32'h04;
  localparam logic [31:0] A_EDGE    = BASE + 32'h08;
  localparam logic [31:0] A_SWSET   = BASE + 32'h0C;
  localparam logic [31:0] A_ACTIVE  = BASE + 32'h10;
  localparam logic [31:0] A_HIGHEST = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  src;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  interrupts;

  int checks = 0;
  int errors = 0;

  intr_ctrl #(
    .NSRC        (8),
    .BASE_ADDR   (BASE),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .src        (src),
    .memwrite   (memwrite),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .readdata   (readdata),
    .interrupts (interrupts)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    dataadr = addr;
    #1;
    chk(tag, readdata, exp);
  endtask

  // Drive a store so it takes effect on the next rising edge
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    memwrite  = 1'b1;
    dataadr   = addr;
    writedata = data;
    step(1);
    memwrite  = 1'b0;
    writedata = '0;
  endtask

  initial begin
    reset = 1'b1; src = '0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    step(2);
    reset = 1'b0;

    // Reset state
    rd("rst_pend", A_PEND, 32'h0);
    rd("rst_mask", A_MASK, 32'h0);
    rd("rst_edge", A_EDGE, 32'hFF);
    rd("rst_highest", A_HIGHEST, 32'h0);
    chk("rst_irq", 32'(interrupts), 32'h0);

    // Edge capture of a one-cycle pulse on src[1]
    wr(A_MASK, 32'h02);
    src = 8'h02;
    step(1);                      // sampling edge k
    src = 8'h00;
    step(1);                      // k+1
    rd("edge_pend_k1", A_PEND, 32'h0);
    step(1);                      // k+2
    rd("edge_pend_k2", A_PEND, 32'h02);
    chk("edge_irq_k2", 32'(interrupts), 32'h0);
    step(1);                      // k+3
    chk("edge_irq_k3", 32'(interrupts), 32'h02);
    rd("edge_highest", A_HIGHEST, 32'h8000_0001);
    rd("edge_active", A_ACTIVE, 32'h02);

    // W1C colliding with a fresh edge: set wins
    src = 8'h02;
    step(1);                      // k
    src = 8'h00;
    step(1);                      // k+1, rise is high until k+2
    wr(A_PEND, 32'h02);           // W1C lands on k+2
    rd("collide_pend", A_PEND, 32'h02);
    wr(A_PEND, 32'h02);
    rd("w1c_pend", A_PEND, 32'h0);
    step(1);
    chk("w1c_irq", 32'(interrupts), 32'h0);

    // Level mode
    wr(A_EDGE, 32'h00);
    wr(A_MASK, 32'hFF);
    src = 8'h81;
    step(1);                      // k
    step(1);                      // k+1
    rd("lvl_pend_k1", A_PEND, 32'h0);
    step(1);                      // k+2
    rd("lvl_pend_k2", A_PEND, 32'h81);
    wr(A_PEND, 32'h80);           // k+3
    rd("lvl_w1c", A_PEND, 32'h81);
    chk("lvl_irq", 32'(interrupts), 32'h81);
    step(1);                      // k+4, last high sample
    src = 8'h00;
    step(1);                      // j
    step(1);                      // j+1
    rd("lvl_pend_j1", A_PEND, 32'h81);
    step(1);                      // j+2
    rd("lvl_pend_j2", A_PEND, 32'h0);

    // Software set with partial mask
    wr(A_EDGE, 32'hFF);
    wr(A_MASK, 32'h20);
    step(1);
    rd("mode_switch_pend", A_PEND, 32'h0);
    wr(A_SWSET, 32'h30);
    rd("sw_pend", A_PEND, 32'h30);
    rd("sw_active", A_ACTIVE, 32'h20);
    rd("sw_highest", A_HIGHEST, 32'h8000_0005);
    rd("sw_swset_rd", A_SWSET, 32'h0);
    chk("sw_irq_now", 32'(interrupts), 32'h0);
    step(1);
    chk("sw_irq_next", 32'(interrupts), 32'h20);
    wr(A_MASK, 32'h30);
    rd("sw_highest_prio", A_HIGHEST, 32'h8000_0004);

    // Unmapped and out-of-window stores
    wr(BASE + 32'h40, 32'hFFFF_FFFF);
    wr(32'h0000_0014, 32'hFFFF_FFFF);
    wr(32'h0000_0004, 32'h0000_0000);
    rd("unmap_pend", A_PEND, 32'h30);
    rd("unmap_mask", A_MASK, 32'h30);
    rd("unmap_edge", A_EDGE, 32'hFF);
    rd("unmap_rd40", BASE + 32'h40, 32'h0);
    rd("outwin_rd", 32'h0000_0014, 32'h0);
    rd("bytelane_rd", A_MASK + 32'h3, 32'h30);

    // Reset while an event is in the synchroniser
    wr(A_PEND, 32'h30);
    rd("pre_rst_pend", A_PEND, 32'h0);
    src = 8'h08;
    step(1);                      // captured in stage 0
    reset = 1'b1;
    src = 8'h00;
    step(1);
    reset = 1'b0;
    step(4);
    rd("mid_rst_pend", A_PEND, 32'h0);
    rd("mid_rst_mask", A_MASK, 32'h0);
    rd("mid_rst_edge", A_EDGE, 32'hFF);
    chk("mid_rst_irq", 32'(interrupts), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Memory-mapped interrupt controller that sits directly upstream of the MIPS `top` core's 8-bit `interrupts` input. It synchronises eight external sources and latches them as pending, either on a rising edge or as a level. It then applies a software mask and drives the registered result onto the core's `interrupts` lines. Software reaches its registers through the core's existing store bus (`memwrite`/`dataadr`/`writedata`), and a combinational `readdata` path feeds the load mux.

## Interface
- `NSRC`, 8: number of interrupt sources; `NSRC` must be ≤ 31.
- `BASE_ADDR`, 32'hFFFF_FF00: byte address of register 0; it must be 256-byte aligned.
- `SYNC_STAGES`, 2: synchroniser depth per source; the minimum is 2.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `src` in NSRC: raw interrupt sources, asynchronous to `clk`.
- `memwrite` in 1: store strobe from the core.
- `dataadr` in 32: load/store byte address from the core.
- `writedata` in 32: store data from the core.
- `readdata` out 32: register read data. Combinational from `dataadr`.
- `interrupts` out NSRC: masked pending lines to the core. Registered.

## Operation
- A register hit requires `dataadr[31:8] == BASE_ADDR[31:8]`. The register is selected by `dataadr[7:2]`, and `dataadr[1:0]` is ignored.
- Writes take effect only when `memwrite` is high on a register hit.
- Unmapped offsets inside the window read 0 and ignore writes. Outside the window, `readdata` is 0.
- Register map:
  - 0x00 PEND (R/W1C): pending bits.
  - 0x04 MASK (R/W): enable bits.
  - 0x08 EDGE (R/W): per-source mode; 1 = rising-edge latched, 0 = level.
  - 0x0C SWSET (W): writing 1 to a bit sets that pending bit; reads return 0.
  - 0x10 ACTIVE (R): PEND & MASK.
  - 0x14 HIGHEST (R): bit 31 = any active; bits 4:0 = index of the lowest-numbered active bit (bit 0 has highest priority); reads 0 when nothing is active.
- Edge-mode source: the pending bit is set when the synchronised value is 1 and the previous synchronised value was 0. The bit then holds until W1C.
- Level-mode source: the pending bit equals the synchronised level every cycle. W1C on it has no lasting effect, and SWSET is overridden next cycle.
- If a set (edge or SWSET) and a W1C hit the same bit in the same cycle, the set wins, so no event is lost.
- Changing EDGE from level to edge keeps the current pending value. The edge detector keeps tracking the synchronised value in both modes, so the switch does not create a spurious edge.
- `interrupts <= PEND & MASK` every cycle.

## Timing
- Reset values: all synchroniser flops, edge-history flops and PEND are 0; MASK = 0; EDGE = all ones; `interrupts` = 0. `readdata` reflects these values immediately.
- Source latency: a `src` rising edge sampled at clock edge k produces:
  - synchronised value high at k+SYNC_STAGES−1;
  - PEND set at k+SYNC_STAGES;
  - `interrupts` high at k+SYNC_STAGES+1 (k+3 with default parameters).
- A pulse on `src` must be at least one `clk` period wide to be captured; shorter pulses may be missed.
- Register writes: MASK/EDGE/PEND/SWSET update at the write edge, and `interrupts` reflects the change one cycle later.
- Reads are same-cycle combinational and return state before any write in that cycle.
- Reset asserted mid-operation clears everything at that edge, including events in flight in the synchronisers.

## Structure
- Package `intr_pkg`:
  - register offset constants (`INTR_PEND`, `INTR_MASK`, `INTR_EDGE`, `INTR_SWSET`, `INTR_ACTIVE`, `INTR_HIGHEST`);
  - reset constants for MASK and EDGE.
- Sub-module `intr_sync`: one-bit `SYNC_STAGES` synchroniser plus the previous-value flop. Outputs are `level` and `rise`. It is instantiated NSRC times with a generate loop.
- The top module holds the register file, the set/clear logic, the priority encoder and the read mux.

## Test plan
- Reset, then read 0x00/0x04/0x08/0x14 → 0, 0, 0xFF, 0; `interrupts` = 0.
- Write MASK = 0x02, then pulse `src[1]` high for one cycle. → PEND = 0x02 and `interrupts` = 0x02 three cycles after the sampling edge; HIGHEST = 0x8000_0001.
- With PEND = 0x02, write 0x02 to PEND in the same cycle a new synchronised edge on source 1 arrives. → PEND stays 0x02 (set wins). A second W1C with no new edge clears it to 0.
- EDGE = 0x00, MASK = 0xFF: hold `src` = 0x81 for 5 cycles, then drop it. → PEND follows 0x81 and then 0x00 at the same latency; W1C on 0x80 while `src[7]` is held has no effect.
- Write SWSET = 0x30 with MASK = 0x20. → PEND = 0x30, ACTIVE = 0x20, HIGHEST = 0x8000_0005, `interrupts` = 0x20 the next cycle.
- Store to BASE_ADDR+0x40 and to 0x0000_0014. → no register changes; `readdata` = 0 for both addresses. Then assert `reset` mid-pulse on `src[3]`. → PEND remains 0 after reset is released.
